// File: rtl/bch_syndrome_stream.sv
// Purpose: streaming BCH syndrome generator, one received bit per cycle, 2T syndromes over GF(2^M).
// Latency: result registered the cycle after the accept of bit N-1; frame_err one cycle after the offending accept.
// Backpressure: in_ready drops while an unread result is held (out_valid && !out_ready); no bit is lost.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     bit-stream handshake; in_bit is r_(N-1) first, r_0 last; in_last marks end of frame
//   out_valid/out_ready   result handshake for syn (S_j at syn[j*M-1 -: M], S_1 in LSBs) and syn_zero
//   frame_err             one-cycle pulse when in_last disagrees with the frame counter
//
// Build option BCH_SYN_SQUARE_EN: only odd-index accumulators are built; even syndromes are
// derived at the output register as S_2k = S_k^2. Without it all 2T accumulators are built.
module bch_syndrome_stream #(
   parameter int         M         = 5,
   parameter int         T         = 2,
   parameter logic [M:0] PRIM_POLY = 6'h25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*T*M-1:0] syn,
   output logic             syn_zero,
   output logic             frame_err
);

   localparam int N  = (1 << M) - 1;
   localparam int SW = 2 * T * M;
`ifdef BCH_SYN_SQUARE_EN
   localparam int NACC = T;
`else
   localparam int NACC = 2 * T;
`endif

   // Multiply by alpha: shift up one degree and fold x^M back using the primitive polynomial.
   function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
      logic [M-1:0] r;
      r = {a[M-2:0], 1'b0};
      if (a[M-1]) r = r ^ PRIM_POLY[M-1:0];
      return r;
   endfunction

   // Constant multiply by alpha^e; e is fixed per accumulator so this folds to an XOR network.
   function automatic logic [M-1:0] gf_mul_apow(input logic [M-1:0] a, input int e);
      logic [M-1:0] r;
      r = a;
      for (int i = 0; i < e; i++) r = gf_xtime(r);
      return r;
   endfunction

   // Evaluation exponent of accumulator slot k.
   function automatic int acc_exp(input int k);
`ifdef BCH_SYN_SQUARE_EN
      return 2 * k + 1;
`else
      return k + 1;
`endif
   endfunction

`ifdef BCH_SYN_SQUARE_EN
   // Squaring is linear over GF(2): bit i of the input contributes alpha^(2i).
   function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
      logic [M-1:0] r;
      logic [M-1:0] p;
      r = '0;
      p = {{(M-1){1'b0}}, 1'b1};
      for (int i = 0; i < M; i++) begin
         if (a[i]) r = r ^ p;
         p = gf_xtime(gf_xtime(p));
      end
      return r;
   endfunction
`endif

   // Map accumulator slots onto the packed syndrome word.
   function automatic logic [SW-1:0] build_syn(input logic [NACC*M-1:0] a);
      logic [SW-1:0] s;
      s = '0;
`ifdef BCH_SYN_SQUARE_EN
      // Ascending j guarantees S_(j/2) is already filled when an even index needs it.
      for (int j = 1; j <= 2 * T; j++) begin
         if (j % 2 == 1) s[j*M-1 -: M] = a[((j-1)/2)*M +: M];
         else            s[j*M-1 -: M] = gf_sq(s[(j/2)*M-1 -: M]);
      end
`else
      s = a;
`endif
      return s;
   endfunction

   logic [M-1:0]      cnt_q, cnt_d;
   logic [NACC*M-1:0] acc_q, acc_d;
   logic [NACC*M-1:0] acc_step;
   logic [SW-1:0]     syn_q, syn_d;
   logic [SW-1:0]     syn_next;
   logic              syn_zero_q, syn_zero_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              accept;
   logic              at_end;

   assign in_ready  = !rst && !(out_valid_q && !out_ready);
   assign accept    = in_valid && in_ready;
   assign at_end    = (cnt_q == M'(N - 1));

   assign out_valid = out_valid_q;
   assign syn       = syn_q;
   assign syn_zero  = syn_zero_q;
   assign frame_err = frame_err_q;

   // Horner step; the first bit of a frame restarts every accumulator instead of scaling stale state.
   always_comb begin
      acc_step = '0;
      for (int k = 0; k < NACC; k++) begin
         acc_step[k*M +: M] = ((cnt_q == '0) ? '0 : gf_mul_apow(acc_q[k*M +: M], acc_exp(k)))
                              ^ {{(M-1){1'b0}}, in_bit};
      end
      syn_next = build_syn(acc_step);
   end

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      syn_d       = syn_q;
      syn_zero_d  = syn_zero_q;
      frame_err_d = 1'b0;
      out_valid_d = out_valid_q && !out_ready;
      if (accept) begin
         if (at_end) begin
            // Counter decides completion; a missing in_last is flagged but the result still goes out.
            cnt_d       = '0;
            acc_d       = acc_step;
            syn_d       = syn_next;
            syn_zero_d  = (syn_next == '0);
            out_valid_d = 1'b1;
            frame_err_d = !in_last;
         end else if (in_last) begin
            // Early end marker: drop the partial frame; cnt==0 clears the accumulators on the next bit.
            cnt_d       = '0;
            frame_err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_step;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         syn_q       <= '0;
         syn_zero_q  <= 1'b0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         syn_q       <= syn_d;
         syn_zero_q  <= syn_zero_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Purpose: self-checking bench for bch_syndrome_stream (M=5, T=2, x^5+x^2+1).
// Latency: a per-cycle reference compares every output against a polynomial-evaluation model.
// Backpressure: out_ready is stalled for a window during back-to-back frames.
module tb_bch_syndrome_stream;

   localparam int M  = 5;
   localparam int T  = 2;
   localparam int N  = 31;
   localparam int SW = 2 * T * M;

   localparam logic [30:0] R_ZERO = 31'h0;
   localparam logic [30:0] R0     = 31'h1;
   localparam logic [30:0] R1     = 31'h2;
   localparam logic [30:0] R5     = 31'h20;
   localparam logic [30:0] R_HIGH = 31'h7FF0_0000;

   localparam logic [SW-1:0] SYN_R0 = 20'h08421;
   localparam logic [SW-1:0] SYN_R1 = 20'h82082;
   localparam logic [SW-1:0] SYN_R5 = 20'h67E25;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_bit;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] syn;
   logic          syn_zero;
   logic          frame_err;

   int total = 0;
   int bad   = 0;
   int stall_cycles = 0;

   bch_syndrome_stream dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .syn       (syn),
      .syn_zero  (syn_zero),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int            apow [0:N-1];
   logic          frame [0:N-1];
   int            nbits;
   logic          mdl_valid;
   logic [SW-1:0] mdl_syn;
   logic          mdl_zero;
   logic          mdl_err;

   initial begin
      int v;
      v = 1;
      for (int i = 0; i < N; i++) begin
         apow[i] = v;
         v = v << 1;
         if ((v & 32) != 0) v = v ^ 'h25;
      end
      nbits = 0; mdl_valid = 0; mdl_syn = '0; mdl_zero = 0; mdl_err = 0;
   end

   // S_j = sum of alpha^(i*j) over set coefficients r_i; frame[p] holds r_(N-1-p).
   function automatic logic [SW-1:0] eval_syn();
      logic [SW-1:0] r;
      int s;
      r = '0;
      for (int j = 1; j <= 2 * T; j++) begin
         s = 0;
         for (int p = 0; p < N; p++)
            if (frame[p]) s = s ^ apow[((N - 1 - p) * j) % N];
         r[j*M-1 -: M] = s[M-1:0];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      logic acc;
      acc = in_valid && !rst && !(mdl_valid && !out_ready);
      if (rst) begin
         mdl_valid = 0; mdl_syn = '0; mdl_zero = 0; mdl_err = 0; nbits = 0;
      end else begin
         mdl_err = 0;
         if (mdl_valid && out_ready) mdl_valid = 0;
         if (acc) begin
            frame[nbits] = in_bit;
            if (nbits == N - 1) begin
               mdl_syn   = eval_syn();
               mdl_zero  = (mdl_syn == '0);
               mdl_valid = 1;
               mdl_err   = !in_last;
               nbits     = 0;
            end else if (in_last) begin
               mdl_err = 1;
               nbits   = 0;
            end else begin
               nbits++;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cyc_in_ready",  in_ready,  !rst && !(mdl_valid && !out_ready));
      chk("cyc_out_valid", out_valid, mdl_valid);
      chk("cyc_frame_err", frame_err, mdl_err);
      chk("cyc_syn",       syn,       mdl_syn);
      chk("cyc_syn_zero",  syn_zero,  mdl_zero);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b, input logic l);
      logic took;
      int guard;
      in_valid = 1'b1; in_bit = b; in_last = l;
      took = 1'b0; guard = 0;
      while (!took && guard < 100) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk); #1;
         if (!took) begin
            guard++;
            stall_cycles++;
         end
      end
      if (!took) chk("send_timeout", 32'd0, 32'd1);
   endtask

   // Sends the first nsend coefficients r_30 downward; in_last on the bit numbered last_at (1-based, 0 = never).
   task automatic send_frame(input logic [30:0] r, input int nsend, input int last_at);
      for (int k = 0; k < nsend; k++)
         send_bit(r[N-1-k], (k + 1 == last_at));
   endtask

   task automatic expect_result(input string nm, input logic [SW-1:0] lit);
      @(negedge clk);
      chk({nm, "_valid"}, out_valid, 1'b1);
      chk({nm, "_syn"},   syn, lit);
      chk({nm, "_zero"},  syn_zero, (lit == '0));
      chk({nm, "_model"}, mdl_syn, lit);
      tick();
   endtask

   task automatic stall_ctl();
      int guard;
      guard = 0;
      while (!out_valid && guard < 200) begin
         tick();
         guard++;
      end
      if (!out_valid) chk("stall_wait_timeout", 32'd0, 32'd1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready",  in_ready,  1'b0);
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_syn",       syn,       SYN_R5);
         tick();
      end
      out_ready = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready",  in_ready,  1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_syn",       syn,       20'h0);
      chk("rst_syn_zero",  syn_zero,  1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      // All-zero frame: result right after the 31st accept, no bubbles
      stall_cycles = 0;
      send_frame(R_ZERO, N, N);
      in_valid = 1'b0;
      @(negedge clk);
      chk("zero_valid",   out_valid, 1'b1);
      chk("zero_syn",     syn,       20'h0);
      chk("zero_szero",   syn_zero,  1'b1);
      chk("zero_err",     frame_err, 1'b0);
      chk("zero_bubbles", stall_cycles, 32'd0);
      tick();
      repeat (2) tick();

      // Single-coefficient frames
      send_frame(R0, N, N);
      in_valid = 1'b0;
      expect_result("r0", SYN_R0);
      repeat (2) tick();

      send_frame(R1, N, N);
      in_valid = 1'b0;
      expect_result("r1", SYN_R1);
      repeat (2) tick();

      send_frame(R5, N, N);
      in_valid = 1'b0;
      expect_result("r5", SYN_R5);
      repeat (2) tick();

      // Back-to-back r_5 frames with a 5-cycle output stall after the first result
      stall_cycles = 0;
      fork
         begin
            send_frame(R5, N, N);
            send_frame(R5, N, N);
            in_valid = 1'b0;
         end
         stall_ctl();
      join
      expect_result("r5_second", SYN_R5);
      chk("b2b_stalls", stall_cycles, 32'd5);
      repeat (2) tick();

      // Early in_last on bit 11 aborts the frame
      send_frame(R_HIGH, 11, 11);
      in_valid = 1'b0;
      @(negedge clk);
      chk("abort_err",   frame_err, 1'b1);
      chk("abort_valid", out_valid, 1'b0);
      tick();
      @(negedge clk);
      chk("abort_err_pulse", frame_err, 1'b0);
      chk("abort_valid2",    out_valid, 1'b0);
      tick();

      // Clean zero frame after the abort must not carry stale accumulator state
      send_frame(R_ZERO, N, N);
      in_valid = 1'b0;
      expect_result("post_abort", 20'h0);
      repeat (2) tick();

      // 31st bit without in_last: valid result plus frame_err
      send_frame(R1, N, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("nolast_valid", out_valid, 1'b1);
      chk("nolast_err",   frame_err, 1'b1);
      chk("nolast_syn",   syn,       SYN_R1);
      tick();
      @(negedge clk);
      chk("nolast_err_pulse", frame_err, 1'b0);
      tick();
      repeat (2) tick();

      // Reset in the middle of an r_5 frame
      send_frame(R5, 15, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_syn",   syn,       20'h0);
      chk("mid_rst_zero",  syn_zero,  1'b0);
      chk("mid_rst_err",   frame_err, 1'b0);
      tick();

      send_frame(R0, N, N);
      in_valid = 1'b0;
      expect_result("after_rst_r0", SYN_R0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bch_syndrome_stream.md
# bch_syndrome_stream

Streaming syndrome generator for binary BCH codes over GF(2^M), primitive length N = 2^M-1, correction capability T. It accepts one received codeword bit per cycle under a valid/ready handshake and evaluates the received polynomial at α^1…α^2T by Horner accumulation. It presents the 2T syndromes, each M bits, as one registered word with its own valid/ready handshake. It is the generalised front end of the BCH decode chain, ahead of the key-equation solver, Chien search and corrector; M=5, T=2 covers the current BCH(31,21) path.

## Interface

Parameters:
- M, 5, field degree; N = 2^M-1 derived locally.
- T, 2, correction capability; 2T syndromes produced.
- PRIM_POLY, 6'h25, primitive polynomial, M+1 bits (x^5+x^2+1 default).

Ports:
- clk  in  1  clock; one clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_bit/in_last valid.
- in_ready  out  1  block accepts a bit this cycle.
- in_bit  in  1  received coefficient; first accepted bit of a frame is r_(N-1), last is r_0.
- in_last  in  1  sender's end-of-frame marker.
- out_valid  out  1  syn/syn_zero valid.
- out_ready  in  1  consumer accepts result.
- syn  out  2T*M  S_j occupies bits [j*M-1 -: M], j=1..2T (S_1 in LSBs).
- syn_zero  out  1  all syndromes zero (no detectable error).
- frame_err  out  1  one-cycle pulse on in_last/counter mismatch.

## Operation

- Accept = in_valid && in_ready. in_ready = !rst && !(out_valid && !out_ready).
- Frame counter cnt, 0..N-1, width M. It increments on accept and wraps to 0 after the last bit. The counter is authoritative for frame length.
- Per accumulator A_j on accept: A_j <= (cnt==0 ? 0 : A_j·α^j) ^ {0…,in_bit}. Use constant GF multipliers derived from PRIM_POLY. No generic multiplier, no lookup tables.
- Frame completion is an accept with cnt==N-1:
  - syn <= final accumulator values, which include this bit.
  - syn_zero <= (all zero).
  - out_valid <= 1.
- Output buffer:
  - out_valid clears on out_valid && out_ready, unless a new completion occurs in the same cycle; in that case syn reloads and out_valid stays 1.
  - syn holds stable while out_valid && !out_ready.
- Framing checks:
  - in_last on accept with cnt!=N-1: abort the frame. cnt <= 0, no output update, frame_err pulses one cycle.
  - cnt==N-1 accepted with in_last=0: the frame completes normally and frame_err also pulses.
- Reset values: out_valid=0, syn=0, syn_zero=0, frame_err=0, cnt=0, accumulators=0. in_ready is 0 while rst is high.
- Reset mid-frame discards the partial frame and any unread result.

## Timing

- Throughput: 1 bit/cycle. Back-to-back frames run with zero bubbles while out_ready=1.
- Latency: out_valid rises the cycle after the accept of bit N-1.
- frame_err asserts the cycle after the offending accept, for exactly one cycle.
- Stall: while out_valid && !out_ready, in_ready=0. No bit is lost. Accumulation resumes the cycle out_ready is seen high.
- There is no combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.

## Configuration

- BCH_SYN_SQUARE_EN defined: only the T odd-index accumulators (j=1,3,…,2T-1) are built. Even syndromes are derived at the output register as S_2k = (S_k)^2, using the linear GF squaring network. Outputs, latency and handshake are bit- and cycle-identical to the full build.
- Undefined: all 2T accumulators are built and each syndrome is accumulated directly.

## Test plan

M=5, T=2, PRIM_POLY=6'h25 unless noted; run both macro settings.

- All-zero 31-bit frame, out_ready=1 -> out_valid on cycle 32, syn=0, syn_zero=1, frame_err=0.
- Single 1 as the last bit (r_0) -> S1..S4 = 5'b00001 each, syn_zero=0.
- Single 1 as the second-to-last bit (r_1) -> S1=00010, S2=00100, S3=01000, S4=10000.
- Single 1 at r_5 -> S1=00101, S2=10001, S3=11111, S4=01100. Next: the same frame back-to-back twice with out_ready=0 for 5 cycles after the first result -> in_ready low for those 5 cycles, syn stable, both results correct, no dropped bits.
- in_last on the 11th bit -> frame_err pulse, no out_valid. Following clean zero frame -> syn=0. A 31st bit with in_last=0 -> valid result plus frame_err pulse.
- rst asserted for 1 cycle at bit 15 of an r_5 frame -> all outputs 0. A fresh r_0 frame -> S1..S4=00001.
